fixed_to_ieee_encoder: RTL

FIXED_TO_IEEE_ENCODER -- requirements
Module: fixed_to_ieee_encoder

---
 rtl/fp_pkg.sv | 37 +++
 rtl/fixed_to_ieee_encoder.sv | 87 ++++++++
 2 files changed

// File: rtl/fp_pkg.sv
// Shared constants, state type and packing helper for the fixed-point to
// IEEE-754 single-precision encoder.
package fp_pkg;

    localparam int unsigned EXP_BIAS   = 127;
    localparam int unsigned FIX_INT_W  = 8;
    localparam int unsigned FIX_FRAC_W = 8;
    localparam int unsigned IEEE_W     = 32;

    localparam int unsigned FIX_W  = FIX_INT_W + FIX_FRAC_W;
    localparam int unsigned K_W    = 4;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned PAD_W  = MAN_W - (FIX_W - 1);
    // Exponent when the leading one already sits in the top bit of the operand.
    localparam int unsigned EXP_TOP = EXP_BIAS + FIX_INT_W - 1;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        PACK,
        DONE
    } enc_state_t;

    // Packs a normalised magnitude (leading one in bit FIX_W-1) shifted k times.
    function automatic logic [IEEE_W-1:0] pack_ieee(input logic            s,
                                                    input logic [FIX_W-1:0] m,
                                                    input logic [K_W-1:0]   k);
        logic [EXP_W-1:0] e;
        e = EXP_W'(EXP_TOP) - {{(EXP_W - K_W){1'b0}}, k};
        if (m == '0) begin
            return {s, {(IEEE_W - 1){1'b0}}};
        end
        return {s, e, m[FIX_W-2:0], {PAD_W{1'b0}}};
    endfunction

endpackage

// File: rtl/fixed_to_ieee_encoder.sv
// Iterative unsigned 8.8 fixed-point to IEEE-754 single encoder: normalises by
// shifting one bit per cycle, then packs sign, exponent and mantissa.
module fixed_to_ieee_encoder
    import fp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  sign_bit,
    input  logic [FIX_INT_W-1:0]  int_part,
    input  logic [FIX_FRAC_W-1:0] frac_part,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IEEE_W-1:0]     ieee_out
);

    enc_state_t          state_q, state_d;
    logic [FIX_W-1:0]    m_q, m_d;
    logic [K_W-1:0]      k_q, k_d;
    logic                sign_q, sign_d;
    logic                out_valid_q, out_valid_d;
    logic [IEEE_W-1:0]   ieee_q, ieee_d;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign ieee_out  = ieee_q;

    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        k_d         = k_q;
        sign_d      = sign_q;
        out_valid_d = out_valid_q;
        ieee_d      = ieee_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = sign_bit;
                    m_d     = {int_part, frac_part};
                    k_d     = '0;
                    state_d = NORM;
                end
            end
            NORM: begin
                // Zero never normalises; it leaves with k = 0 and packs as signed zero.
                if (m_q[FIX_W-1] || (m_q == '0)) begin
                    state_d = PACK;
                end else begin
                    m_d = {m_q[FIX_W-2:0], 1'b0};
                    k_d = k_q + 1'b1;
                end
            end
            PACK: begin
                ieee_d      = pack_ieee(sign_q, m_q, k_q);
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            m_q         <= '0;
            k_q         <= '0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            ieee_q      <= '0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            k_q         <= k_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
            ieee_q      <= ieee_d;
        end
    end

endmodule
